// File: rtl/gpio_hex_pkg.sv
// Shared types and constants for the GPIO hex display sink.
package gpio_hex_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam int          NBCD      = 10;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; entry 0 sits in the low bits.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble to active-low 7-segment code.
module seg7_encode
  import gpio_hex_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/gpio_hex_sink.sv
// GPIO hex-CSR sink: multi-cycle double-dabble to eight blanked 7-segment digits.
// Optional GPIO_HEX_RAW_EN adds raw_mode, which shows the word as hex nibbles.
module gpio_hex_sink
  import gpio_hex_pkg::*;
#(
  parameter int NDIG = 8,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gpio_we,
  input  logic [DW-1:0] gpio_out,
`ifdef GPIO_HEX_RAW_EN
  input  logic          raw_mode,
`endif
  output logic [6:0]    hex0,
  output logic [6:0]    hex1,
  output logic [6:0]    hex2,
  output logic [6:0]    hex3,
  output logic [6:0]    hex4,
  output logic [6:0]    hex5,
  output logic [6:0]    hex6,
  output logic [6:0]    hex7,
  output logic          busy,
  output logic          ovf
);

  localparam int CW = $clog2(DW);
  localparam int BW = NBCD * 4;

  state_e                    state_q, state_d;
  logic [DW-1:0]             bin_q, bin_d;
  logic [BW-1:0]             bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      raw_q, raw_d;
  logic                      raw_in;
  logic                      load_en;
  logic [NDIG-1:0][6:0]      hex_q, hex_d;
  logic                      ovf_q, ovf_d;
  logic [3:0]                dig [NDIG];
  logic [6:0]                seg [NDIG];
  logic                      nz_above;

`ifdef GPIO_HEX_RAW_EN
  assign raw_in = raw_mode;
`else
  assign raw_in = 1'b0;
`endif

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    raw_d   = raw_q;
    load_en = 1'b0;
    case (state_q)
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) state_d = LOAD;
      end
      LOAD: begin
        load_en = 1'b1;
        state_d = IDLE;
      end
      default: ;
    endcase
    // A new write always wins, even on the edge that completes LOAD.
    if (gpio_we) begin
      bin_d   = gpio_out;
      bcd_d   = '0;
      cnt_d   = '0;
      raw_d   = raw_in;
      state_d = raw_in ? LOAD : SHIFT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      raw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      raw_q   <= raw_d;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NDIG; g++) begin : g_dig
      assign dig[g] = raw_q ? bin_q[4*g +: 4] : bcd_q[4*g +: 4];
      seg7_encode u_enc (
        .nib_i (dig[g]),
        .seg_o (seg[g])
      );
    end
  endgenerate

  // Blank a digit when it and every higher displayed digit are zero.
  always_comb begin
    nz_above = 1'b0;
    hex_d    = {NDIG{SEG_BLANK}};
    hex_d[0] = seg[0];
    for (int k = NDIG - 1; k >= 1; k--) begin
      nz_above = nz_above | (dig[k] != 4'd0);
      hex_d[k] = (raw_q || nz_above) ? seg[k] : SEG_BLANK;
    end
    ovf_d = raw_q ? 1'b0 : (|bcd_q[BW-1:NDIG*4]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_q <= {{(NDIG-1){SEG_BLANK}}, SEG_LUT[0]};
      ovf_q <= 1'b0;
    end else if (load_en) begin
      hex_q <= hex_d;
      ovf_q <= ovf_d;
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign hex6 = hex_q[6];
  assign hex7 = hex_q[7];
  assign busy = (state_q != IDLE);
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_gpio_hex_sink.sv
// Self-checking bench for gpio_hex_sink: vector table, corner sequences, random vs model.
module tb_gpio_hex_sink;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic        gpio_we;
  logic [31:0] gpio_out;
`ifdef GPIO_HEX_RAW_EN
  logic        raw_mode;
`endif
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic        busy, ovf;

  int checks = 0;
  int errors = 0;

  gpio_hex_sink dut (
    .clk      (clk),
    .rst      (rst),
    .gpio_we  (gpio_we),
    .gpio_out (gpio_out),
`ifdef GPIO_HEX_RAW_EN
    .raw_mode (raw_mode),
`endif
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3),
    .hex4     (hex4),
    .hex5     (hex5),
    .hex6     (hex6),
    .hex7     (hex7),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
    logic [56:0] exp;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [56:0] disp();
    return {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0, ovf};
  endfunction

  function automatic logic [6:0] dec_seg(input int unsigned d);
    case (d)
      0: return S0;  1: return S1;  2: return S2;  3: return S3;  4: return S4;
      5: return S5;  6: return S6;  7: return S7;  8: return S8;  default: return S9;
    endcase
  endfunction

  // Reference: low 8 decimal digits, blank above the highest nonzero one.
  function automatic logic [56:0] model(input logic [31:0] v);
    int unsigned shown = v % 32'd100000000;
    int unsigned d [8];
    int top = 0;
    logic [56:0] r;
    for (int k = 0; k < 8; k++) begin
      d[k] = shown % 10;
      shown = shown / 10;
      if (d[k] != 0) top = k;
    end
    for (int k = 0; k < 8; k++) r[7*k+1 +: 7] = (k > top) ? SB : dec_seg(d[k]);
    r[0] = (v >= 32'd100000000);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] v);
    gpio_out = v;
    gpio_we  = 1'b1;
    @(negedge clk);
    gpio_we  = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  int          cyc;
  int          held_bad;
  logic [56:0] prev;
  logic [31:0] rv;

  initial begin
    tbl[0] = '{"zero",     32'd0,          {SB, SB, SB, SB, SB, SB, SB, S0, 1'b0}};
    tbl[1] = '{"d1234",    32'd1234,       {SB, SB, SB, SB, S1, S2, S3, S4, 1'b0}};
    tbl[2] = '{"allones",  32'hFFFFFFFF,   {S9, S4, S9, S6, S7, S2, S9, S5, 1'b1}};
    tbl[3] = '{"max8",     32'd99999999,   {S9, S9, S9, S9, S9, S9, S9, S9, 1'b0}};
    tbl[4] = '{"1e8",      32'd100000000,  {SB, SB, SB, SB, SB, SB, SB, S0, 1'b1}};
    tbl[5] = '{"ten",      32'd10,         {SB, SB, SB, SB, SB, SB, S1, S0, 1'b0}};
    tbl[6] = '{"innerz",   32'd20000005,   {S2, S0, S0, S0, S0, S0, S0, S5, 1'b0}};
    tbl[7] = '{"1e9",      32'd1000000000, {SB, SB, SB, SB, SB, SB, SB, S0, 1'b1}};

    rst = 1'b1;
    gpio_we = 1'b0;
    gpio_out = '0;
`ifdef GPIO_HEX_RAW_EN
    raw_mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_disp", 64'(disp()), 64'({SB, SB, SB, SB, SB, SB, SB, S0, 1'b0}));
    check("reset_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 8; i++) begin
      do_write(tbl[i].val);
      wait_done(cyc);
      check({tbl[i].name, "_lat"}, 64'(cyc), 64'd33);
      check(tbl[i].name, 64'(disp()), 64'(tbl[i].exp));
    end

    // Abort: 5 is written then superseded by 77 three cycles later.
    prev = disp();
    held_bad = 0;
    do_write(32'd5);
    @(negedge clk);
    @(negedge clk);
    do_write(32'd77);
    cyc = 0;
    while (busy && cyc < 100) begin
      if (disp() !== prev) held_bad++;
      @(negedge clk);
      cyc++;
    end
    check("abort_hold", 64'(held_bad), 64'd0);
    check("abort_lat", 64'(cyc), 64'd33);
    check("abort_val", 64'(disp()), 64'(model(32'd77)));

    // Write landing on the LOAD edge: old result still loads, new one follows.
    do_write(32'd4321);
    repeat (32) @(negedge clk);
    do_write(32'd808);
    check("loadwr_disp", 64'(disp()), 64'(model(32'd4321)));
    check("loadwr_busy", 64'(busy), 64'd1);
    wait_done(cyc);
    check("loadwr_lat", 64'(cyc), 64'd33);
    check("loadwr_val", 64'(disp()), 64'(model(32'd808)));

    // Strobe held high: last value wins, latency measured from the final write.
    prev = disp();
    gpio_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      gpio_out = 32'd1000 + 32'(i);
      @(negedge clk);
    end
    gpio_we = 1'b0;
    check("held_hold", 64'(disp()), 64'(prev));
    wait_done(cyc);
    check("held_lat", 64'(cyc), 64'd33);
    check("held_val", 64'(disp()), 64'(model(32'd1004)));

    // Asynchronous reset mid-conversion.
    do_write(32'd12345678);
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_disp", 64'(disp()), 64'({SB, SB, SB, SB, SB, SB, SB, S0, 1'b0}));
    check("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_after_disp", 64'(disp()), 64'({SB, SB, SB, SB, SB, SB, SB, S0, 1'b0}));
    check("rst_after_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0:       rv = $urandom;
        1:       rv = $urandom_range(0, 999);
        default: rv = $urandom_range(0, 99999999);
      endcase
      do_write(rv);
      wait_done(cyc);
      check("rand_lat", 64'(cyc), 64'd33);
      check("rand_val", 64'(disp()), 64'(model(rv)));
    end

`ifdef GPIO_HEX_RAW_EN
    raw_mode = 1'b1;
    do_write(32'hDEADBEEF);
    raw_mode = 1'b0;
    check("raw_busy", 64'(busy), 64'd1);
    wait_done(cyc);
    check("raw_lat", 64'(cyc), 64'd1);
    check("raw_val", 64'(disp()),
          64'({7'b0100001, 7'b0000110, 7'b0001000, 7'b0100001,
               7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110, 1'b0}));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_hex_sink.md
Name: gpio_hex_sink

Overview:
- Consumer end of the core's GPIO write path. It accepts the hex-CSR write strobe and 32-bit data produced by instruction decode, and drives the board's eight 7-segment digits.
- It latches each written word and converts it to decimal with an iterative, multi-cycle double-dabble.
- It then registers the segment patterns with leading-zero blanking.
- It sits between the datapath's GPIO output and the top-level HEX pins.

Parameters:
- NDIG, 8, number of displayed digits (HEX0..HEX7); fixed at 8 in this revision.
- DW, 32, width of the GPIO data word; the conversion runs for DW iterations.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  asynchronous active-high reset.
- gpio_we  in  1  write strobe, one-cycle pulse per hex-CSR write.
- gpio_out  in  32  unsigned value to display; sampled only when gpio_we=1.
- hex0..hex7  out  7 each  active-low segments {g,f,e,d,c,b,a}; hex0 is the least-significant digit.
- busy  out  1  high while a conversion is in progress.
- ovf  out  1  high when the displayed value exceeds 99999999 (decimal digits 9..8 nonzero).

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - hex0=7'b1000000 ("0"), hex1..hex7=7'b1111111 (blank).
  - busy=0, ovf=0, FSM=IDLE, internal shift/BCD registers cleared.
- FSM states:
  - IDLE: busy=0.
  - SHIFT: busy=1, step counter counts 0..DW-1.
  - LOAD: busy=1, lasts one cycle.
- IDLE -> SHIFT: gpio_we=1 at edge N. Capture gpio_out into the binary shift register, clear the 40-bit BCD register (10 digits), clear the counter.
- SHIFT, each edge:
  - First add 3 to every BCD digit >= 5.
  - Then shift {bcd,bin} left by one.
  - Counter increments; after DW shifts go to LOAD.
- LOAD, on the next edge:
  - Register the segment patterns for digits 7..0 and register ovf = |bcd[39:32].
  - Return to IDLE.
- Latency: gpio_we at edge N -> new hex/ovf visible after edge N+DW+1 (N+33). busy is high from after edge N until after edge N+33.
- Leading-zero blanking: digit k (k>=1) is blank if it and all higher displayed digits are 0. hex0 always shows its digit.
- Overflow: only the low 8 decimal digits are displayed; ovf=1 flags the truncation. Blanking is evaluated on the displayed 8 digits only.
- Write during SHIFT or LOAD: abort the conversion and restart from the new gpio_out at that edge. Old display values are held; the aborted value is never shown. Last write wins.
- Write in the same cycle LOAD completes: LOAD's display update still occurs, and the FSM enters SHIFT with the new value.
- gpio_we held high continuously: a restart occurs every cycle; the display updates only 33 edges after the last write.
- Display outputs are registered and never glitch between updates.
- Segment codes (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111

Optional Feature:
- Macro GPIO_HEX_RAW_EN.
- Defined:
  - Adds input port raw_mode (1 bit).
  - When raw_mode=1 at the write edge, bypass conversion: go directly to LOAD, and hex digit k = nibble gpio_out[4k+3:4k].
  - Codes A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - No leading-zero blanking, ovf=0.
  - Latency is 2 edges (capture, then LOAD).
- Not defined: no raw_mode port; every write is decimal-converted.

Decomposition:
- Package gpio_hex_pkg:
  - state enum {IDLE, SHIFT, LOAD}
  - SEG_BLANK localparam
  - 16-entry segment-code constant array
  - NBCD=10 localparam
- Sub-module seg7_encode: combinational 4-bit nibble -> 7-bit active-low code, instantiated once per digit.
- FSM, double-dabble datapath and blanking logic stay in gpio_hex_sink.

Test Plan:
- Reset release, no writes -> hex0=1000000, hex1..7=1111111, busy=0, ovf=0.
- Write 32'd1234 -> busy for 33 cycles; then hex3..0 = 1,2,3,4, hex7..4 blank, ovf=0.
- Write 32'hFFFFFFFF (4294967295) -> hex7..0 = 9,4,9,6,7,2,9,5, ovf=1.
- Write 5, then write 77 three cycles later -> display goes directly from its prior value to "77" 33 edges after the second write; "5" never appears.
- Write 12345678, assert rst at cycle 10 of SHIFT -> immediately returns to the reset display; busy=0; no later update.
- With GPIO_HEX_RAW_EN: raw_mode=1, write 32'hDEADBEEF -> after 2 edges hex7..0 = d,E,A,d,b,E,E,F, ovf=0.
